arm_decode_stage: RTL and testbench

//  Registered ARM (ARMv4) instruction-decode stage between fetch and register-read.

---
 rtl/arm_decode_stage.sv | 168 ++++++++++++++++
 tb/tb_arm_decode_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_decode_stage.sv
// Registered ARMv4 instruction-decode stage: classifies fetched words and buffers them in a DEPTH-entry FIFO.
// Optional feature macro ARM_COND_EVAL_EN: evaluates the head condition field against the NZCV flags input.
module arm_decode_stage #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic [3:0]      flags,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_itype,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic [3:0]      out_cond,
    output logic [3:0]      out_rn,
    output logic [3:0]      out_rd,
    output logic [3:0]      out_rs,
    output logic [3:0]      out_rm,
    output logic            out_cond_pass
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    localparam logic [3:0] CLS_MUL       = 4'd0;
    localparam logic [3:0] CLS_MULL      = 4'd1;
    localparam logic [3:0] CLS_BX        = 4'd2;
    localparam logic [3:0] CLS_SWP       = 4'd3;
    localparam logic [3:0] CLS_HALF_R    = 4'd4;
    localparam logic [3:0] CLS_HALF_I    = 4'd5;
    localparam logic [3:0] CLS_SIGNED_DT = 4'd6;
    localparam logic [3:0] CLS_DATA_PROC = 4'd7;
    localparam logic [3:0] CLS_LDR_STR   = 4'd8;
    localparam logic [3:0] CLS_UNDEF     = 4'd9;
    localparam logic [3:0] CLS_BLOCK_DT  = 4'd10;
    localparam logic [3:0] CLS_BRANCH    = 4'd11;
    localparam logic [3:0] CLS_COPROC    = 4'd12;

    logic [31:0]     r_instr_mem [DEPTH];
    logic [PC_W-1:0] r_pc_mem    [DEPTH];
    logic [3:0]      r_itype_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    logic [3:0] w_itype;

    // Priority class decode; multiply/swap/halfword space is only reached when bits 7 and 4 are both set.
    function automatic logic [3:0] f_classify(input logic [31:0] i);
        logic [3:0] c;
        c = CLS_MUL;
        case (i[27:26])
            2'b11: c = CLS_COPROC;
            2'b10: c = i[25] ? CLS_BRANCH : CLS_BLOCK_DT;
            2'b01: c = (i[25] & i[4]) ? CLS_UNDEF : CLS_LDR_STR;
            default: begin
                if (i[25])                      c = CLS_DATA_PROC;
                else if (i[27:4] == 24'h12FFF1) c = CLS_BX;
                else if (!(i[7] & i[4]))        c = CLS_DATA_PROC;
                else if (i[6])                  c = CLS_SIGNED_DT;
                else if (i[5])                  c = i[22] ? CLS_HALF_I : CLS_HALF_R;
                else if (i[24])                 c = CLS_SWP;
                else if (i[23])                 c = CLS_MULL;
                else                            c = CLS_MUL;
            end
        endcase
        return c;
    endfunction

    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_empty  = (r_count == CNT_W'(0));
    assign w_push   = in_valid & ~w_full & ~flush;
    assign w_pop    = ~w_empty & out_ready & ~flush;
    assign w_itype  = f_classify(in_instr);

    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty;

    // Occupancy and pointers; flush wins over any same-cycle transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= in_instr;
            r_pc_mem[r_wr_ptr]    <= in_pc;
            r_itype_mem[r_wr_ptr] <= w_itype;
        end
    end

    assign out_instr = r_instr_mem[r_rd_ptr];
    assign out_pc    = r_pc_mem[r_rd_ptr];
    assign out_itype = w_empty ? CLS_UNDEF : r_itype_mem[r_rd_ptr];
    assign out_cond  = out_instr[31:28];
    assign out_rn    = out_instr[19:16];
    assign out_rd    = out_instr[15:12];
    assign out_rs    = out_instr[11:8];
    assign out_rm    = out_instr[3:0];

`ifdef ARM_COND_EVAL_EN
    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = flags[3];
    assign w_z = flags[2];
    assign w_c = flags[1];
    assign w_v = flags[0];

    // Head condition evaluated against the live flags, not the flags at push time.
    always_comb begin
        out_cond_pass = 1'b0;
        case (out_cond)
            4'h0: out_cond_pass = w_z;
            4'h1: out_cond_pass = ~w_z;
            4'h2: out_cond_pass = w_c;
            4'h3: out_cond_pass = ~w_c;
            4'h4: out_cond_pass = w_n;
            4'h5: out_cond_pass = ~w_n;
            4'h6: out_cond_pass = w_v;
            4'h7: out_cond_pass = ~w_v;
            4'h8: out_cond_pass = w_c & ~w_z;
            4'h9: out_cond_pass = ~w_c | w_z;
            4'hA: out_cond_pass = (w_n == w_v);
            4'hB: out_cond_pass = (w_n != w_v);
            4'hC: out_cond_pass = ~w_z & (w_n == w_v);
            4'hD: out_cond_pass = w_z | (w_n != w_v);
            4'hE: out_cond_pass = 1'b1;
            default: out_cond_pass = 1'b0;
        endcase
    end
`else
    logic w_unused_flags;

    assign w_unused_flags = ^flags;
    assign out_cond_pass  = 1'b1;
`endif

endmodule

// File: tb/tb_arm_decode_stage.sv
// Bench for arm_decode_stage: directed class/field/backpressure/flush/reset/cond steps, then random traffic against a queue model.
module tb_arm_decode_stage;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_instr = '0;
    logic [PC_W-1:0] in_pc = '0;
    logic [3:0]      flags = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [3:0]      out_itype;
    logic [31:0]     out_instr;
    logic [PC_W-1:0] out_pc;
    logic [3:0]      out_cond;
    logic [3:0]      out_rn;
    logic [3:0]      out_rd;
    logic [3:0]      out_rs;
    logic [3:0]      out_rm;
    logic            out_cond_pass;

    arm_decode_stage #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flags(flags),
        .out_valid(out_valid), .out_ready(out_ready), .out_itype(out_itype),
        .out_instr(out_instr), .out_pc(out_pc), .out_cond(out_cond),
        .out_rn(out_rn), .out_rd(out_rd), .out_rs(out_rs), .out_rm(out_rm),
        .out_cond_pass(out_cond_pass)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [3:0]  cls;
    } ent_t;

    ent_t        q[$];
    logic [3:0]  t_cls = '0;
    int          total = 0;
    int          bad = 0;

`ifdef ARM_COND_EVAL_EN
    localparam bit COND_ON = 1'b1;
`else
    localparam bit COND_ON = 1'b0;
`endif

    // Class code straight from the listed decode rules.
    function automatic logic [3:0] ref_class(input logic [31:0] w);
        int grp = int'(w[27:26]);
        if (grp == 3) return 4'd12;
        if (grp == 2) return w[25] ? 4'd11 : 4'd10;
        if (grp == 1) return (w[25] && w[4]) ? 4'd9 : 4'd8;
        if (w[25]) return 4'd7;
        if (w[27:4] == 24'h12FFF1) return 4'd2;
        if (!(w[7] && w[4])) return 4'd7;
        if (w[6]) return 4'd6;
        if (w[5]) return w[22] ? 4'd5 : 4'd4;
        if (w[24]) return 4'd3;
        if (w[23]) return 4'd1;
        return 4'd0;
    endfunction

    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        bit n = f[3];
        bit z = f[2];
        bit cy = f[1];
        bit v = f[0];
        bit r;
        if (!COND_ON) return 1'b1;
        case (c)
            4'h0: r = z;            4'h1: r = !z;
            4'h2: r = cy;           4'h3: r = !cy;
            4'h4: r = n;            4'h5: r = !n;
            4'h6: r = v;            4'h7: r = !v;
            4'h8: r = cy && !z;     4'h9: r = !cy || z;
            4'hA: r = (n == v);     4'hB: r = (n != v);
            4'hC: r = !z && (n == v);
            4'hD: r = z || (n != v);
            4'hE: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        ent_t e;
        chk({tag, ".in_ready"},  64'(in_ready),  64'(q.size() < int'(DEPTH)));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            e = q[0];
            chk({tag, ".itype"}, 64'(out_itype), 64'(e.cls));
            chk({tag, ".instr"}, 64'(out_instr), 64'(e.instr));
            chk({tag, ".pc"},    64'(out_pc),    64'(e.pc));
            chk({tag, ".cond"},  64'(out_cond),  64'((e.instr >> 28) & 32'hF));
            chk({tag, ".rn"},    64'(out_rn),    64'((e.instr >> 16) & 32'hF));
            chk({tag, ".rd"},    64'(out_rd),    64'((e.instr >> 12) & 32'hF));
            chk({tag, ".rs"},    64'(out_rs),    64'((e.instr >> 8) & 32'hF));
            chk({tag, ".rm"},    64'(out_rm),    64'(e.instr & 32'hF));
            chk({tag, ".pass"},  64'(out_cond_pass), 64'(ref_pass(e.instr[31:28], flags)));
        end
    endtask

    // One clock: check at the negedge, predict the transfer, advance the model at the posedge.
    task automatic cyc(input string tag);
        bit   push;
        bit   pop;
        ent_t e;
        check_state(tag);
        push = in_valid && (q.size() < int'(DEPTH)) && !flush;
        pop  = (q.size() != 0) && out_ready && !flush;
        e.instr = in_instr;
        e.pc    = in_pc;
        e.cls   = t_cls;
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic push_word(input logic [31:0] w, input logic [31:0] pc, input logic [3:0] cls,
                             input string tag, input int max_cyc);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_instr = w;
        in_pc    = pc;
        t_cls    = cls;
        for (int k = 0; k < max_cyc && !done; k++) begin
            done = (q.size() < int'(DEPTH)) && !flush;
            cyc(tag);
        end
        in_valid = 1'b0;
        total++;
        assert (done) else begin
            bad++;
            $error("FAIL %s.accept observed=timeout expected=accepted", tag);
        end
    endtask

    task automatic idle(input int n, input string tag);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) cyc(tag);
    endtask

    logic [31:0] t1_words [13] = '{32'hE1A00000, 32'hE12FFF1E, 32'hE0010392, 32'hE0821293,
                                   32'hE1010092, 32'hE19100B2, 32'hE1D100B2, 32'hE1D100D0,
                                   32'hE5910000, 32'hE7F000F0, 32'hE8BD8000, 32'hEA000000,
                                   32'hEF000000};
    logic [3:0]  t1_cls [13]   = '{4'd7, 4'd2, 4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6,
                                   4'd8, 4'd9, 4'd10, 4'd11, 4'd12};

    initial begin
        logic [31:0] w;
        int          kind;

        // Reset state while rst is still asserted
        #3;
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.itype", 64'(out_itype), 64'd9);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc("rst.idle");

        // T1: one word per cycle, drained immediately
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) push_word(t1_words[i], 32'h1000 + 32'(i * 4), t1_cls[i], "t1", 4);
        idle(2, "t1.drain");

        // T2: field extraction with one-cycle latency
        out_ready = 1'b0;
        push_word(32'hE0821293, 32'h100, 4'd1, "t2", 2);
        chk("t2.valid", 64'(out_valid), 64'd1);
        chk("t2.pc", 64'(out_pc), 64'h100);
        chk("t2.rn", 64'(out_rn), 64'd2);
        chk("t2.rd", 64'(out_rd), 64'd1);
        chk("t2.rs", 64'(out_rs), 64'd2);
        chk("t2.rm", 64'(out_rm), 64'd3);
        out_ready = 1'b1;
        idle(2, "t2.drain");

        // T3: backpressure holds C until space frees up
        out_ready = 1'b0;
        push_word(32'hE1A00001, 32'h200, ref_class(32'hE1A00001), "t3.a", 1);
        push_word(32'hE5910002, 32'h204, ref_class(32'hE5910002), "t3.b", 1);
        chk("t3.full", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_instr = 32'hEA000003;
        in_pc    = 32'h208;
        t_cls    = ref_class(32'hEA000003);
        cyc("t3.hold");
        cyc("t3.hold");
        out_ready = 1'b1;
        push_word(32'hEA000003, 32'h208, ref_class(32'hEA000003), "t3.c", 4);
        idle(3, "t3.drain");
        chk("t3.empty", 64'(out_valid), 64'd0);

        // T4: flush with two entries and a word on the input
        out_ready = 1'b0;
        push_word(32'hE0010392, 32'h300, 4'd0, "t4.fill", 2);
        push_word(32'hE1010092, 32'h304, 4'd3, "t4.fill", 2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'hEF000000;
        t_cls    = 4'd12;
        cyc("t4.flush");
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t4.post_valid", 64'(out_valid), 64'd0);
        chk("t4.post_ready", 64'(in_ready), 64'd1);
        cyc("t4.post");

        // T4: asynchronous reset in the middle of the low phase
        push_word(32'hE19100B2, 32'h400, 4'd4, "t4.refill", 2);
        push_word(32'hE1D100B2, 32'h404, 4'd5, "t4.refill", 2);
        #2;
        rst = 1'b1;
        #1;
        chk("t4.arst_valid", 64'(out_valid), 64'd0);
        chk("t4.arst_ready", 64'(in_ready), 64'd1);
        chk("t4.arst_itype", 64'(out_itype), 64'd9);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        cyc("t4.after_rst");

        // T5: condition evaluation of the held head entry
        push_word(32'h0A000000, 32'h500, 4'd11, "t5.eq", 2);
        flags = 4'b0000;
        chk("t5.eq_z0", 64'(out_cond_pass), COND_ON ? 64'd0 : 64'd1);
        cyc("t5.eq_z0");
        flags = 4'b0100;
        chk("t5.eq_z1", 64'(out_cond_pass), 64'd1);
        cyc("t5.eq_z1");
        flush = 1'b1;
        cyc("t5.flush");
        flush = 1'b0;
        push_word(32'hF0000000, 32'h504, 4'd7, "t5.nv", 2);
        chk("t5.nv", 64'(out_cond_pass), COND_ON ? 64'd0 : 64'd1);
        flush = 1'b1;
        cyc("t5.flush");
        flush = 1'b0;
        push_word(32'hE0000000, 32'h508, 4'd7, "t5.al", 2);
        chk("t5.al", 64'(out_cond_pass), 64'd1);
        out_ready = 1'b1;
        idle(2, "t5.drain");

        // T6: simultaneous push and pop at count one
        out_ready = 1'b0;
        push_word(32'hE0821293, 32'h600, 4'd1, "t6.seed", 2);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w = 32'hE1A00000 | 32'(i);
            push_word(w, 32'h604 + 32'(i * 4), 4'd7, "t6.pp", 1);
            chk("t6.valid", 64'(out_valid), 64'd1);
        end
        idle(2, "t6.drain");

        // Random traffic against the queue model
        for (int n = 0; n < 600; n++) begin
            kind = int'($urandom_range(0, 5));
            w = $urandom;
            if (kind == 1) w = (w & 32'hF1FFFFFF) | 32'h00000090;
            else if (kind == 2) w = (w & 32'hF000000F) | 32'h012FFF10;
            else if (kind == 3) w = w & 32'hF3FFFFFF;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            flags     = 4'($urandom);
            in_instr  = w;
            in_pc     = $urandom;
            t_cls     = ref_class(w);
            cyc("rnd");
        end
        flush     = 1'b0;
        out_ready = 1'b1;
        idle(3, "rnd.drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
